sent_msg_store: RTL and testbench
=================================

// Module: sent_msg_store
// PURPOSE
// - Parametrised store of outbound FIX messages, indexed by sequence number, with resend replay.
// - Sits beside the FIX transmit path: captures every sent message byte stream.
// - Replays a stored message when a ResendRequest asks for that sequence number.
// - SLOT_CNT direct-mapped slots; slot = seq[log2(SLOT_CNT)-1:0]. Newer messages overwrite older ones.
// PARAMETERS
// - SEQ_W      16   sequence number width
// - SLOT_CNT   16   message slots, power of 2, >=2
// - MSG_BYTES  256  max bytes per slot, power of 2
// - DATA_W     8    byte lane width
// PORTS
// - clk            in   1           clock
// - rst            in   1           synchronous reset, active-high
// - wr_valid_i     in   1           write byte valid (message being sent)
// - wr_last_i      in   1           final byte of message; qualified by wr_valid_i
// - wr_seq_i       in   SEQ_W       message seq number; sampled on first beat only
// - wr_data_i      in   DATA_W      message byte
// - wr_ready_o     out  1           write beat accepted when wr_valid_i & wr_ready_o
// - wr_trunc_o     out  1           1-cycle pulse: message exceeded MSG_BYTES
// - rd_req_i       in   1           resend request; accepted only when rd_busy_o=0
// - rd_seq_i       in   SEQ_W       requested seq number; sampled with rd_req_i
// - rd_busy_o      out  1           replay engine not idle
// - rd_valid_o     out  1           replay byte valid
// - rd_data_o      out  DATA_W      replay byte
// - rd_last_o      out  1           final replay beat
// - rd_cksum_o     out  1           current beat is checksum byte (tied 0 without macro)
// - rd_ready_i     in   1           replay sink ready
// - rd_miss_o      out  1           1-cycle pulse: seq not held (never written/overwritten/truncated)
// BEHAVIOUR
// - Reset: all slot tags invalid; wr_ready_o=1; all other outputs 0; both FSMs idle. Reset mid-message or mid-replay aborts immediately. rd_valid_o=0 on the cycle after rst.
// - Tag per slot: {valid, seq[SEQ_W-1:0], len[log2(MSG_BYTES):0]}.
// - Write FSM: W_IDLE / W_BODY / W_DROP.
//   - W_IDLE, first accepted beat: latch seq, clear target tag valid, write byte at offset 0.
//     - wr_last_i set: commit tag and stay in W_IDLE. Otherwise go to W_BODY.
//   - W_BODY: each accepted beat writes mem[slot][off]; off++.
//     - On wr_last_i: commit tag {1,seq,off+1}, go to W_IDLE.
//   - Beat MSG_BYTES+1 (off would wrap): byte dropped, wr_trunc_o pulses once, tag stays invalid, go to W_DROP.
//   - W_DROP: accept and discard beats until wr_last_i, then go to W_IDLE.
//   - wr_ready_o=0 only in W_IDLE when wr_valid_i targets the slot currently being replayed. Held low until the replay's rd_last_o beat is accepted. No other backpressure.
// - Read FSM: R_IDLE / R_LOOKUP / R_STREAM [/ R_CKSUM].
//   - R_IDLE: rd_req_i latches rd_seq_i, go to R_LOOKUP. rd_busy_o=1 from the next cycle.
//   - R_LOOKUP (1 cycle): hit = tag.valid & tag.seq==req_seq.
//     - Miss: rd_miss_o pulses, go to R_IDLE.
//     - Hit: prefetch byte 0, go to R_STREAM.
//   - Latency: first rd_valid_o asserts 2 cycles after rd_req_i is accepted.
//   - R_STREAM: registered output. rd_data_o, rd_valid_o, rd_last_o hold stable while rd_valid_o & !rd_ready_i.
//     - Next byte presented the cycle after each handshake (full throughput).
//     - rd_last_o on byte len-1; return to R_IDLE after it is accepted.
//   - Lookup of a slot with a write in progress: tag invalid, so miss.
//   - rd_req_i while busy is ignored (not queued).
// CONFIGURATION
// - SENT_MSG_CKSUM_EN defined:
//   - Per-slot 8-bit running sum of stored bytes (mod 256), committed with the tag.
//   - Replay appends one R_CKSUM beat: rd_data_o=sum, rd_cksum_o=1, rd_last_o=1. The last data beat has rd_last_o=0.
// - Undefined: no sum storage, no R_CKSUM state, rd_cksum_o=0, rd_last_o on final data byte.
// TESTING
// - Write seq 5: 0x38,0x3D,0x46 (last on 3rd); req 5 -> beats 0x38,0x3D,0x46, rd_last_o on 0x46, 1st valid 2 cycles after req.
// - Same with SENT_MSG_CKSUM_EN -> 4th beat 0xBB, rd_cksum_o=1, rd_last_o=1; 3rd beat rd_last_o=0.
// - SLOT_CNT=16: write seq 5 then seq 21; req 5 -> rd_miss_o pulse, no rd_valid_o; req 21 -> seq 21 bytes.
// - Write MSG_BYTES+1 bytes as seq 9 -> wr_trunc_o pulses once, on beat 257; req 9 -> rd_miss_o.
// - Replay seq 3 (len 4) with rd_ready_i low 3 cycles on byte 1; start write seq 19 -> data held stable, wr_ready_o=0 until rd_last_o accepted.
// - Assert rst mid-replay of seq 5 -> rd_valid_o=0 next cycle, rd_busy_o=0; req 5 after reset -> rd_miss_o.

Source files
------------

// File: rtl/sent_msg_store.sv
// sent_msg_store: direct-mapped store of outbound FIX messages, indexed by
// sequence number, with byte-stream replay for ResendRequest handling.
// Optional feature macro: SENT_MSG_CKSUM_EN -- keeps a per-slot byte sum and
// appends it as a final checksum beat to every replay.
module sent_msg_store #(
  parameter int unsigned SEQ_W     = 16,
  parameter int unsigned SLOT_CNT  = 16,
  parameter int unsigned MSG_BYTES = 256,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid_i,
  input  logic              wr_last_i,
  input  logic [SEQ_W-1:0]  wr_seq_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              wr_trunc_o,
  input  logic              rd_req_i,
  input  logic [SEQ_W-1:0]  rd_seq_i,
  output logic              rd_busy_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              rd_cksum_o,
  input  logic              rd_ready_i,
  output logic              rd_miss_o
);

  localparam int unsigned SLOT_W = $clog2(SLOT_CNT);
  localparam int unsigned OFF_W  = $clog2(MSG_BYTES);
  localparam int unsigned LEN_W  = OFF_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MSG_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_BODY, W_DROP} w_state_t;
`ifdef SENT_MSG_CKSUM_EN
  typedef enum logic [1:0] {R_IDLE, R_LOOKUP, R_STREAM, R_CKSUM} r_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_LOOKUP, R_STREAM} r_state_t;
`endif

  // Message storage and per-slot tags
  logic [DATA_W-1:0] mem [SLOT_CNT*MSG_BYTES];
  logic [SLOT_CNT-1:0] tag_valid;
  logic [SEQ_W-1:0]    tag_seq [SLOT_CNT];
  logic [LEN_W-1:0]    tag_len [SLOT_CNT];
`ifdef SENT_MSG_CKSUM_EN
  logic [DATA_W-1:0]   tag_sum [SLOT_CNT];
`endif

  // Write side
  w_state_t          w_state, w_state_nxt;
  logic [SEQ_W-1:0]  wr_seq_q, wr_seq_cur;
  logic [LEN_W-1:0]  wr_off_q, wr_off_cur;
  logic [SLOT_W-1:0] wr_slot;
  logic              wr_fire, wr_first, wr_store, wr_commit;
`ifdef SENT_MSG_CKSUM_EN
  logic [DATA_W-1:0] wr_sum_q, wr_sum_cur;
`endif

  // Read side
  r_state_t          r_state, r_state_nxt;
  logic [SEQ_W-1:0]  rd_seq_q;
  logic [SLOT_W-1:0] rd_slot;
  logic [LEN_W-1:0]  rd_off_q, rd_len_q, rd_load_off;
  logic              rd_hit, rd_fire, rd_accept, rd_load, rd_finish, rd_miss_set;
  logic              rd_valid_q, rd_last_q, rd_miss_q;
  logic [DATA_W-1:0] rd_data_q;
`ifdef SENT_MSG_CKSUM_EN
  logic [DATA_W-1:0] rd_sum_q;
  logic              rd_sum_load, rd_cksum_q;
`else
  logic [LEN_W-1:0]  rd_len_cur;
`endif

  // The first beat of a message carries its own seq, so the slot comes
  // straight from the input while idle and from the latched seq afterwards.
  assign wr_seq_cur = (w_state == W_IDLE) ? wr_seq_i : wr_seq_q;
  assign wr_off_cur = (w_state == W_IDLE) ? '0 : wr_off_q;
  assign wr_slot    = wr_seq_cur[SLOT_W-1:0];
`ifdef SENT_MSG_CKSUM_EN
  assign wr_sum_cur = (w_state == W_IDLE) ? wr_data_i : wr_sum_q + wr_data_i;
`endif

  // A new message may not start on the slot the replay engine is using
  // (lookup included, so a hit cannot race the tag invalidation).
  assign wr_ready_o = !((w_state == W_IDLE) && wr_valid_i &&
                        (r_state != R_IDLE) && (wr_slot == rd_slot));
  assign wr_fire    = wr_valid_i && wr_ready_o;

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // Write FSM next state, store/commit strobes and truncation pulse
  always_comb begin
    w_state_nxt = w_state;
    wr_first    = 1'b0;
    wr_store    = 1'b0;
    wr_commit   = 1'b0;
    wr_trunc_o  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (wr_fire) begin
          wr_first = 1'b1;
          wr_store = 1'b1;
          if (wr_last_i) wr_commit = 1'b1;
          else           w_state_nxt = W_BODY;
        end
      end
      W_BODY: begin
        if (wr_fire) begin
          if (wr_off_q == LEN_MAX) begin
            wr_trunc_o  = 1'b1;
            w_state_nxt = wr_last_i ? W_IDLE : W_DROP;
          end else begin
            wr_store = 1'b1;
            if (wr_last_i) begin
              wr_commit   = 1'b1;
              w_state_nxt = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (wr_fire && wr_last_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write-side message context: seq, next offset and running sum
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_seq_q <= '0;
      wr_off_q <= '0;
`ifdef SENT_MSG_CKSUM_EN
      wr_sum_q <= '0;
`endif
    end else if (wr_store) begin
      wr_seq_q <= wr_seq_cur;
      wr_off_q <= wr_off_cur + LEN_W'(1);
`ifdef SENT_MSG_CKSUM_EN
      wr_sum_q <= wr_sum_cur;
`endif
    end
  end

  // Byte storage
  always_ff @(posedge clk) begin
    if (wr_store) mem[{wr_slot, wr_off_cur[OFF_W-1:0]}] <= wr_data_i;
  end

  // Tag valid bits: invalidated on the first beat, set on a clean commit
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      if (wr_first)  tag_valid[wr_slot] <= 1'b0;
      if (wr_commit) tag_valid[wr_slot] <= 1'b1;
    end
  end

  // Tag payload, only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      tag_seq[wr_slot] <= wr_seq_cur;
      tag_len[wr_slot] <= wr_off_cur + LEN_W'(1);
`ifdef SENT_MSG_CKSUM_EN
      tag_sum[wr_slot] <= wr_sum_cur;
`endif
    end
  end

  assign rd_slot = rd_seq_q[SLOT_W-1:0];
  assign rd_hit  = tag_valid[rd_slot] && (tag_seq[rd_slot] == rd_seq_q);
  assign rd_fire = rd_valid_q && rd_ready_i;
`ifndef SENT_MSG_CKSUM_EN
  assign rd_len_cur = (r_state == R_LOOKUP) ? tag_len[rd_slot] : rd_len_q;
`endif

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  // Read FSM next state and datapath strobes
  always_comb begin
    r_state_nxt = r_state;
    rd_accept   = 1'b0;
    rd_load     = 1'b0;
    rd_load_off = rd_off_q + LEN_W'(1);
    rd_finish   = 1'b0;
    rd_miss_set = 1'b0;
`ifdef SENT_MSG_CKSUM_EN
    rd_sum_load = 1'b0;
`endif
    case (r_state)
      R_IDLE: begin
        if (rd_req_i) begin
          rd_accept   = 1'b1;
          r_state_nxt = R_LOOKUP;
        end
      end
      R_LOOKUP: begin
        if (rd_hit) begin
          rd_load     = 1'b1;
          rd_load_off = '0;
          r_state_nxt = R_STREAM;
        end else begin
          rd_miss_set = 1'b1;
          r_state_nxt = R_IDLE;
        end
      end
      R_STREAM: begin
        if (rd_fire) begin
          if (rd_off_q == rd_len_q - LEN_W'(1)) begin
`ifdef SENT_MSG_CKSUM_EN
            rd_sum_load = 1'b1;
            r_state_nxt = R_CKSUM;
`else
            rd_finish   = 1'b1;
            r_state_nxt = R_IDLE;
`endif
          end else begin
            rd_load = 1'b1;
          end
        end
      end
`ifdef SENT_MSG_CKSUM_EN
      R_CKSUM: begin
        if (rd_fire) begin
          rd_finish   = 1'b1;
          r_state_nxt = R_IDLE;
        end
      end
`endif
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Replay output register: loads the next byte after each handshake and
  // holds everything stable while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_seq_q   <= '0;
      rd_off_q   <= '0;
      rd_len_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_data_q  <= '0;
`ifdef SENT_MSG_CKSUM_EN
      rd_sum_q   <= '0;
      rd_cksum_q <= 1'b0;
`endif
    end else begin
      rd_miss_q <= rd_miss_set;
      if (rd_accept) rd_seq_q <= rd_seq_i;
      if (r_state == R_LOOKUP) begin
        rd_len_q <= tag_len[rd_slot];
`ifdef SENT_MSG_CKSUM_EN
        rd_sum_q <= tag_sum[rd_slot];
`endif
      end
      if (rd_load) begin
        rd_valid_q <= 1'b1;
        rd_off_q   <= rd_load_off;
        rd_data_q  <= mem[{rd_slot, rd_load_off[OFF_W-1:0]}];
`ifdef SENT_MSG_CKSUM_EN
        rd_last_q  <= 1'b0;
        rd_cksum_q <= 1'b0;
`else
        rd_last_q  <= (rd_load_off == rd_len_cur - LEN_W'(1));
`endif
      end
`ifdef SENT_MSG_CKSUM_EN
      else if (rd_sum_load) begin
        rd_data_q  <= rd_sum_q;
        rd_last_q  <= 1'b1;
        rd_cksum_q <= 1'b1;
      end
`endif
      else if (rd_finish) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
`ifdef SENT_MSG_CKSUM_EN
        rd_cksum_q <= 1'b0;
`endif
      end
    end
  end

  assign rd_busy_o  = (r_state != R_IDLE);
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign rd_miss_o  = rd_miss_q;
`ifdef SENT_MSG_CKSUM_EN
  assign rd_cksum_o = rd_cksum_q;
`else
  assign rd_cksum_o = 1'b0;
`endif

endmodule

// File: tb/tb_sent_msg_store.sv
// Self-checking bench for sent_msg_store: scoreboard of expected replay beats,
// one task per scenario.
module tb_sent_msg_store;

  logic        clk;
  logic        rst;
  logic        wr_valid_i, wr_last_i, wr_ready_o, wr_trunc_o;
  logic [15:0] wr_seq_i;
  logic [7:0]  wr_data_i;
  logic        rd_req_i, rd_busy_o, rd_valid_o, rd_last_o, rd_cksum_o, rd_ready_i, rd_miss_o;
  logic [15:0] rd_seq_i;
  logic [7:0]  rd_data_o;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       ck;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] wbuf[$];
  int n_cmp = 0;
  int n_bad = 0;
  int trunc_n;
  int trunc_beat;

  sent_msg_store #(
    .SEQ_W(16), .SLOT_CNT(16), .MSG_BYTES(256), .DATA_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid_i), .wr_last_i(wr_last_i), .wr_seq_i(wr_seq_i),
    .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o), .wr_trunc_o(wr_trunc_o),
    .rd_req_i(rd_req_i), .rd_seq_i(rd_seq_i), .rd_busy_o(rd_busy_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .rd_cksum_o(rd_cksum_o), .rd_ready_i(rd_ready_i), .rd_miss_o(rd_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Queue the replay beats expected for the message currently in wbuf
  task automatic push_msg();
    beat_t b;
`ifdef SENT_MSG_CKSUM_EN
    logic [7:0] sum = 8'h00;
`endif
    for (int i = 0; i < wbuf.size(); i++) begin
      b.d  = wbuf[i];
      b.ck = 1'b0;
`ifdef SENT_MSG_CKSUM_EN
      sum    = sum + wbuf[i];
      b.last = 1'b0;
`else
      b.last = (i == wbuf.size() - 1);
`endif
      exp_q.push_back(b);
    end
`ifdef SENT_MSG_CKSUM_EN
    b.d = sum; b.last = 1'b1; b.ck = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // Send wbuf as one message; records truncation pulses seen per beat
  task automatic write_msg(input logic [15:0] seq);
    int i = 0;
    int n = wbuf.size();
    trunc_n = 0;
    trunc_beat = -1;
    for (int g = 0; g < 1000 && i < n; g++) begin
      wr_valid_i = 1'b1;
      wr_seq_i   = seq;
      wr_data_i  = wbuf[i];
      wr_last_i  = (i == n - 1);
      @(negedge clk);
      if (wr_trunc_o === 1'b1) begin
        trunc_n++;
        trunc_beat = i;
      end
      if (wr_ready_o === 1'b1) i++;
      @(posedge clk); #1;
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    if (i < n) begin
      n_cmp++; n_bad++;
      $display("FAIL write_timeout seq=%0d: accepted %0d beats, required %0d", seq, i, n);
    end
  endtask

  // Request a replay and check it against the scoreboard. Optionally stalls
  // the sink on byte 1 and tries a write to a colliding slot meanwhile.
  task automatic replay(input logic [15:0] seq, input bit exp_miss, input int stall_n,
                        input bit blk_wr, input logic [15:0] blk_seq, input logic [7:0] blk_data);
    int first_valid = -1;
    int miss_n = 0;
    int beats = 0;
    int stall_left = stall_n;
    bit done = 1'b0;
    bit held = 1'b0;
    logic [7:0] held_d;
    logic held_l;
    beat_t e;
    rd_req_i   = 1'b1;
    rd_seq_i   = seq;
    rd_ready_i = 1'b1;
    for (int cyc = 0; cyc < 700 && !done; cyc++) begin
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== held_d || rd_last_o !== held_l) begin
          n_bad++;
          $display("FAIL hold seq=%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   seq, rd_valid_o, rd_data_o, rd_last_o, held_d, held_l);
        end
      end
      held   = (rd_valid_o === 1'b1) && !rd_ready_i;
      held_d = rd_data_o;
      held_l = rd_last_o;
      if (blk_wr && wr_valid_i) begin
        n_cmp++;
        if (wr_ready_o !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_block seq=%0d: wr_ready_o=%b, required 0", blk_seq, wr_ready_o);
        end
      end
      if (rd_valid_o === 1'b1 && first_valid < 0) first_valid = cyc;
      if (rd_miss_o === 1'b1) miss_n++;
      if (rd_valid_o === 1'b1 && rd_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_beat seq=%0d: got d=%h, required no beat", seq, rd_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({rd_data_o, rd_last_o, rd_cksum_o} !== {e.d, e.last, e.ck}) begin
            n_bad++;
            $display("FAIL beat seq=%0d #%0d: got d=%h last=%b ck=%b, required d=%h last=%b ck=%b",
                     seq, beats, rd_data_o, rd_last_o, rd_cksum_o, e.d, e.last, e.ck);
          end
        end
        beats++;
        if (rd_last_o === 1'b1) done = 1'b1;
      end
      if (exp_miss && cyc >= 4) done = 1'b1;
      @(posedge clk); #1;
      rd_req_i = 1'b0;
      if (beats == 1 && stall_left > 0) begin
        rd_ready_i = 1'b0;
        stall_left--;
        if (blk_wr && !wr_valid_i) begin
          wr_valid_i = 1'b1; wr_seq_i = blk_seq; wr_data_i = blk_data; wr_last_i = 1'b1;
        end
      end else begin
        rd_ready_i = 1'b1;
      end
    end
    n_cmp++;
    if (exp_miss) begin
      if (miss_n != 1 || first_valid >= 0) begin
        n_bad++;
        $display("FAIL miss seq=%0d: got miss pulses=%0d first_valid=%0d, required 1 and none",
                 seq, miss_n, first_valid);
      end
    end else begin
      if (!done || first_valid != 2 || miss_n != 0 || exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL replay seq=%0d: got done=%0d latency=%0d misses=%0d left=%0d, required 1/2/0/0",
                 seq, done, first_valid, miss_n, exp_q.size());
      end
    end
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if (rd_busy_o !== 1'b0 || rd_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after seq=%0d: got busy=%b valid=%b, required 0/0", seq, rd_busy_o, rd_valid_o);
    end
    if (blk_wr) begin
      n_cmp++;
      if (wr_ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL wr_unblock seq=%0d: wr_ready_o=%b, required 1", blk_seq, wr_ready_o);
      end
    end
    @(posedge clk); #1;
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_seq_i = '0; wr_data_i = '0;
    rd_req_i = 1'b0; rd_seq_i = '0; rd_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({wr_ready_o, wr_trunc_o, rd_busy_o, rd_valid_o, rd_last_o, rd_cksum_o, rd_miss_o, rd_data_o}
        !== {1'b1, 6'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_in: got rdy=%b tr=%b busy=%b v=%b l=%b ck=%b miss=%b d=%h, required 1,0...",
               wr_ready_o, wr_trunc_o, rd_busy_o, rd_valid_o, rd_last_o, rd_cksum_o, rd_miss_o, rd_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wr_ready_o, rd_busy_o, rd_valid_o, rd_miss_o} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_out: got rdy=%b busy=%b v=%b miss=%b, required 1/0/0/0",
               wr_ready_o, rd_busy_o, rd_valid_o, rd_miss_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wbuf = '{8'h38, 8'h3D, 8'h46};
    write_msg(16'd5);
    push_msg();
    replay(16'd5, 1'b0, 0, 1'b0, 16'd0, 8'h00);
    wbuf = '{8'h5A};
    write_msg(16'd7);
    push_msg();
    replay(16'd7, 1'b0, 0, 1'b0, 16'd0, 8'h00);
  endtask

  task automatic test_overwrite();
    wbuf = '{8'h11, 8'h22};
    write_msg(16'd21);
    replay(16'd5, 1'b1, 0, 1'b0, 16'd0, 8'h00);
    push_msg();
    replay(16'd21, 1'b0, 0, 1'b0, 16'd0, 8'h00);
  endtask

  task automatic test_trunc();
    wbuf.delete();
    for (int i = 0; i < 256; i++) wbuf.push_back(8'((i * 7 + 3) & 255));
    write_msg(16'd10);
    n_cmp++;
    if (trunc_n != 0) begin
      n_bad++;
      $display("FAIL trunc_full: got %0d pulses, required 0", trunc_n);
    end
    push_msg();
    replay(16'd10, 1'b0, 0, 1'b0, 16'd0, 8'h00);
    wbuf.push_back(8'hEE);
    write_msg(16'd9);
    n_cmp++;
    if (trunc_n != 1 || trunc_beat != 256) begin
      n_bad++;
      $display("FAIL trunc_over: got %0d pulses at beat index %0d, required 1 at 256", trunc_n, trunc_beat);
    end
    replay(16'd9, 1'b1, 0, 1'b0, 16'd0, 8'h00);
  endtask

  task automatic test_backpressure();
    wbuf = '{8'h01, 8'h02, 8'h03, 8'h04};
    write_msg(16'd3);
    push_msg();
    replay(16'd3, 1'b0, 3, 1'b1, 16'd19, 8'hA0);
    wbuf = '{8'hA0};
    push_msg();
    replay(16'd19, 1'b0, 0, 1'b0, 16'd0, 8'h00);
  endtask

  task automatic test_reset_mid_replay();
    wbuf = '{8'h38, 8'h3D, 8'h46};
    write_msg(16'd5);
    rd_req_i = 1'b1; rd_seq_i = 16'd5; rd_ready_i = 1'b0;
    @(posedge clk); #1;
    rd_req_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (rd_valid_o !== 1'b1 || rd_busy_o !== 1'b1 || rd_data_o !== 8'h38) begin
      n_bad++;
      $display("FAIL pre_reset: got v=%b busy=%b d=%h, required 1/1/38", rd_valid_o, rd_busy_o, rd_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rd_valid_o !== 1'b0 || rd_busy_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b, required 0/0/1", rd_valid_o, rd_busy_o, wr_ready_o);
    end
    @(posedge clk); #1;
    rd_ready_i = 1'b1;
    replay(16'd5, 1'b1, 0, 1'b0, 16'd0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_trunc();
    test_backpressure();
    test_reset_mid_replay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
